reg_wb_arbiter: RTL

Write-back arbiter that owns the single write port of the RV32I register file. It accepts results from the ALU and load/store unit over valid/ready channels, buffers ALU results in a small FIFO and gives load results priority, with a starvation guard. It also drives one registered write per cycle into the register file and exports a pending-write mask to the hazard logic.

---
 rtl/ripple_pkg.sv | 17 +
 rtl/reg_wb_arbiter_fifo.sv | 86 ++++++++
 rtl/reg_wb_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ripple_pkg.sv
// Shared write-back types for the register-file write port arbiter and its result FIFO.
// Pure declarations; no timing or flow control of its own.
package ripple_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  function automatic logic [31:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    rd_onehot = 32'd1 << rd;
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_fifo.sv
// wb_fifo: DEPTH-entry synchronous FIFO of write-back requests, head visible the cycle after push.
// Push is ignored when full and pop when empty; per-slot rd/valid exported for the pending mask.
module wb_fifo
  import ripple_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  wb_req_t                     push_req,
  input  logic                        pop,
  output wb_req_t                     head,
  output logic                        full,
  output logic                        empty,
  output logic [CNT_W-1:0]            count,
  output logic [DEPTH-1:0]            ent_vld,
  output logic [DEPTH*REG_ADDR_W-1:0] ent_rd
);

  wb_req_t            mem_q [DEPTH];
  wb_req_t            mem_d [DEPTH];
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    ptr_next = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    // Push and pop never target the same slot: that needs the FIFO to be both full and empty.
    if (do_push) begin
      mem_d[wr_ptr_q] = push_req;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end
    if (do_pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = ptr_next(rd_ptr_q);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_comb begin
    ent_rd  = '0;
    ent_vld = vld_q;
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd[i*REG_ADDR_W +: REG_ADDR_W] = mem_q[i].rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Owns the register-file write port: loads write 1 cycle after acceptance, ALU results >= 2 via the FIFO.
// Readies depend only on state/rst; ALU refused while FIFO full, loads refused when the FIFO head is forced.
module reg_wb_arbiter
  import ripple_pkg::*;
#(
  parameter int XLEN      = ripple_pkg::XLEN,
  parameter int DEPTH     = 2,
  parameter int MAX_DEFER = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     pending_mask
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DEF_W = $clog2(MAX_DEFER + 1);

  wb_req_t                     alu_req, lsu_req, fifo_head, win_req;
  logic                        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]            fifo_count;
  logic [DEPTH-1:0]            fifo_ent_vld;
  logic [DEPTH*REG_ADDR_W-1:0] fifo_ent_rd;

  logic [DEF_W-1:0] defer_q, defer_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
  logic             force_head, load_win, any_win;

  assign alu_req.rd   = alu_rd;
  assign alu_req.data = alu_data;
  assign lsu_req.rd   = lsu_rd;
  assign lsu_req.data = lsu_data;

  assign alu_ready  = !rst && (fifo_count < CNT_W'(DEPTH));
  assign fifo_push  = alu_valid && alu_ready && !fifo_full;

  // Starvation guard: once the head has lost MAX_DEFER times in a row, loads are held off for one cycle.
  assign force_head = !fifo_empty && (defer_q == DEF_W'(MAX_DEFER));
  assign lsu_ready  = !rst && !force_head;
  assign load_win   = lsu_valid && lsu_ready;
  assign fifo_pop   = !load_win && !fifo_empty;
  assign any_win    = load_win || fifo_pop;
  assign win_req    = load_win ? lsu_req : fifo_head;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_req (alu_req),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .ent_vld  (fifo_ent_vld),
    .ent_rd   (fifo_ent_rd)
  );

  always_comb begin
    defer_d = defer_q;
    if (fifo_empty || fifo_pop) begin
      defer_d = '0;
    end else if (load_win && (defer_q != DEF_W'(MAX_DEFER))) begin
      defer_d = defer_q + DEF_W'(1);
    end
  end

  always_comb begin
    rf_we_d    = any_win && (win_req.rd != '0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (any_win) begin
      rf_waddr_d = win_req.rd;
      rf_wdata_d = win_req.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      defer_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      defer_q    <= defer_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_ent_vld[i]) begin
        pending_mask = pending_mask | rd_onehot(fifo_ent_rd[i*REG_ADDR_W +: REG_ADDR_W]);
      end
    end
    if (rf_we_q) begin
      pending_mask = pending_mask | rd_onehot(rf_waddr_q);
    end
    pending_mask[0] = 1'b0;
    if (rst) begin
      pending_mask = '0;
    end
  end

endmodule
